// File: rtl/irq_cycle_timer_pkg.sv
// Shared definitions for the M2-cycle IRQ timer used by mapper modules
// (106, FME-7/69, Bandai FCG and similar). Holds the register-select and
// save-state address maps, control bit positions and the legal counter widths.
// Optional prescaler support is selected with the IRQ_PRESCALER_EN macro.
package irq_cycle_timer_pkg;

    // Register select decoded by the owning mapper
    typedef enum logic [2:0] {
        REG_RLD0   = 3'd0,
        REG_RLD1   = 3'd1,
        REG_RLD2   = 3'd2,
        REG_CTRL   = 3'd3,
        REG_ACK    = 3'd4,
        REG_STOP   = 3'd5,
        REG_RELOAD = 3'd6,
        REG_RSVD   = 3'd7
    } reg_sel_e;

    // Save-state byte addresses
    typedef enum logic [2:0] {
        SS_CNT0  = 3'd0,
        SS_CNT1  = 3'd1,
        SS_CNT2  = 3'd2,
        SS_RLD0  = 3'd3,
        SS_RLD1  = 3'd4,
        SS_RLD2  = 3'd5,
        SS_FLAGS = 3'd6,
        SS_PRE   = 3'd7
    } ss_addr_e;

    // Control register bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_DIR  = 2;
    localparam int CTRL_PSEL = 4;

    // Flag byte layout in save-state: {irq, enable, autoreload, dir, psel, 3'b0}
    localparam int FLG_IRQ  = 7;
    localparam int FLG_EN   = 6;
    localparam int FLG_AR   = 5;
    localparam int FLG_DIR  = 4;
    localparam int FLG_PSEL = 3;

    // Legal counter widths
    localparam int CNT_W_8  = 8;
    localparam int CNT_W_16 = 16;
    localparam int CNT_W_24 = 24;

    function automatic bit cnt_w_legal(input int w);
        return (w == CNT_W_8) || (w == CNT_W_16) || (w == CNT_W_24);
    endfunction

endpackage

// File: rtl/irq_prescaler.sv
// 4-bit divide-by-16 prescaler for irq_cycle_timer. Produces a wrap pulse on
// the cycle where it increments from 15 to 0. Only built when the
// IRQ_PRESCALER_EN macro is defined; otherwise this file contributes nothing.
`ifdef IRQ_PRESCALER_EN
module irq_prescaler (
    input  logic       m2,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    output logic [3:0] val,
    output logic       wrap
);

    logic [3:0] pre_q;

    assign val  = pre_q;
    // Wrap is combinational so the counter can step on the same edge
    assign wrap = inc && (pre_q == 4'hF);

    // Prescaler state: reset, save-state load, clear on reload, else count
    always_ff @(negedge m2) begin
        if (rst) begin
            pre_q <= 4'h0;
        end else if (load) begin
            pre_q <= load_val;
        end else if (clr) begin
            pre_q <= 4'h0;
        end else if (inc) begin
            pre_q <= pre_q + 4'h1;
        end
    end

endmodule
`endif

// File: rtl/irq_cycle_timer.sv
// Configurable M2-cycle IRQ timer embedded inside mapper modules. The mapper
// decodes its own addresses into reg_sel and routes irq onward.
// All state changes on the falling edge of m2; map_rst is synchronous.
// Optional feature macro: IRQ_PRESCALER_EN adds a divide-by-16 prescaler
// selected by control bit 4.
module irq_cycle_timer
    import irq_cycle_timer_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit ARM_ON_MSB = 1'b1,
    parameter bit DIR_DEF    = 1'b0
) (
    input  logic             m2,
    input  logic             map_rst,
    input  logic             reg_we,
    input  logic [2:0]       reg_sel,
    input  logic [7:0]       reg_dat,
    input  logic             ss_act,
    input  logic             ss_we,
    input  logic [2:0]       ss_addr,
    input  logic [7:0]       ss_wdat,
    output logic [7:0]       ss_rdat,
    output logic [CNT_W-1:0] cnt,
    output logic             irq
);

    localparam int NB      = CNT_W / 8;
    localparam int MSB_IDX = NB - 1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    if (!cnt_w_legal(CNT_W)) begin : g_bad_width
        $error("irq_cycle_timer: CNT_W must be 8, 16 or 24");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] rld_q;
    logic             irq_q;
    logic             en_q;
    logic             ar_q;
    logic             dir_q;
    logic             psel_q;

    logic             reg_act;
    logic             ss_wr;
    logic             run;
    logic             step;
    logic             term;
    logic             rld_hit;
    logic [CNT_W-1:0] cnt_nxt;

    // Save-state freezes register writes and counting
    assign reg_act = reg_we && !ss_act;
    assign ss_wr   = ss_act && ss_we;
    assign run     = en_q && !reg_we && !ss_act;

    // Reload byte writes only land on bytes that exist at this width
    assign rld_hit = (reg_sel <= REG_RLD2) && (int'(reg_sel) < NB);

    assign term    = dir_q ? (cnt_q == '0) : (cnt_q == '1);
    assign cnt_nxt = dir_q ? (cnt_q - ONE) : (cnt_q + ONE);

`ifdef IRQ_PRESCALER_EN
    logic [3:0] pre_val;
    logic       pre_wrap;
    logic       pre_clr;
    logic       pre_load;

    assign pre_clr  = reg_act && (rld_hit || (reg_sel == REG_RELOAD));
    assign pre_load = ss_wr && (ss_addr == SS_PRE);

    irq_prescaler u_prescaler (
        .m2       (m2),
        .rst      (map_rst),
        .clr      (pre_clr),
        .load     (pre_load),
        .load_val (ss_wdat[3:0]),
        .inc      (run),
        .val      (pre_val),
        .wrap     (pre_wrap)
    );

    // With psel set the counter only advances when the prescaler wraps
    assign step = run && (!psel_q || pre_wrap);

    // Prescale-select bit, writable from control register and save-state
    always_ff @(negedge m2) begin
        if (map_rst) begin
            psel_q <= 1'b0;
        end else if (ss_wr && (ss_addr == SS_FLAGS)) begin
            psel_q <= ss_wdat[FLG_PSEL];
        end else if (reg_act && (reg_sel == REG_CTRL)) begin
            psel_q <= reg_dat[CTRL_PSEL];
        end
    end
`else
    assign psel_q = 1'b0;
    assign step   = run;
`endif

    // Timer state: reset, save-state writes, register writes, then count step
    always_ff @(negedge m2) begin
        if (map_rst) begin
            cnt_q <= '0;
            rld_q <= '0;
            irq_q <= 1'b0;
            en_q  <= 1'b0;
            ar_q  <= 1'b0;
            dir_q <= DIR_DEF;
        end else if (ss_act) begin
            if (ss_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (int'(ss_addr) == int'(SS_CNT0) + b) begin
                        cnt_q[8*b +: 8] <= ss_wdat;
                    end
                    if (int'(ss_addr) == int'(SS_RLD0) + b) begin
                        rld_q[8*b +: 8] <= ss_wdat;
                    end
                end
                if (ss_addr == SS_FLAGS) begin
                    irq_q <= ss_wdat[FLG_IRQ];
                    en_q  <= ss_wdat[FLG_EN];
                    ar_q  <= ss_wdat[FLG_AR];
                    dir_q <= ss_wdat[FLG_DIR];
                end
            end
        end else if (reg_act) begin
            case (reg_sel)
                REG_RLD0, REG_RLD1, REG_RLD2: begin
                    for (int b = 0; b < NB; b++) begin
                        if (int'(reg_sel) == b) begin
                            rld_q[8*b +: 8] <= reg_dat;
                            cnt_q[8*b +: 8] <= reg_dat;
                            if (ARM_ON_MSB && (b == MSB_IDX)) begin
                                en_q <= 1'b1;
                            end
                        end
                    end
                end
                REG_CTRL: begin
                    en_q  <= reg_dat[CTRL_EN];
                    ar_q  <= reg_dat[CTRL_AR];
                    dir_q <= reg_dat[CTRL_DIR];
                end
                REG_ACK: begin
                    irq_q <= 1'b0;
                end
                REG_STOP: begin
                    irq_q <= 1'b0;
                    en_q  <= 1'b0;
                    cnt_q <= '0;
                end
                REG_RELOAD: begin
                    cnt_q <= rld_q;
                end
                default: begin
                end
            endcase
        end else if (step) begin
            if (term) begin
                irq_q <= 1'b1;
                if (ar_q) begin
                    cnt_q <= rld_q;
                end else begin
                    // One-shot: wrap naturally and stop
                    cnt_q <= cnt_nxt;
                    en_q  <= 1'b0;
                end
            end else begin
                cnt_q <= cnt_nxt;
            end
        end
    end

    // Save-state read mux; bytes absent at this width read as FF
    always_comb begin
        ss_rdat = 8'hFF;
        for (int b = 0; b < NB; b++) begin
            if (int'(ss_addr) == int'(SS_CNT0) + b) begin
                ss_rdat = cnt_q[8*b +: 8];
            end
            if (int'(ss_addr) == int'(SS_RLD0) + b) begin
                ss_rdat = rld_q[8*b +: 8];
            end
        end
        if (ss_addr == SS_FLAGS) begin
            ss_rdat = {irq_q, en_q, ar_q, dir_q, psel_q, 3'b000};
        end
`ifdef IRQ_PRESCALER_EN
        if (ss_addr == SS_PRE) begin
            ss_rdat = {4'h0, pre_val};
        end
`endif
    end

    assign cnt = cnt_q;
    assign irq = irq_q;

endmodule
